// File: rtl/issue_instr_buffer_if.sv
// rtl/issue_instr_buffer_if.sv - decode-to-issue handshake bundle for issue_instr_buffer
//
// Signals (directions as seen from the buffer, i.e. the slave modport):
//   flush_i               in   drop all buffered instructions
//   instr_i               in   decoded instruction from decode
//   is_ctrl_flow_i        in   instr_i is a branch/jump
//   instr_valid_i         in   instr_i valid
//   instr_ready_o         out  buffer accepts instr_i
//   decoded_instr_o       out  head entry to issue stage
//   decoded_instr_valid_o out  head entry valid
//   is_ctrl_flow_o        out  head entry is control-flow
//   decoded_instr_ack_i   in   issue stage consumed head
//   resolve_branch_i      in   EX resolved outstanding branch
//   count_o               out  current occupancy
// The master modport is the decode/issue/EX side driving the buffer.

interface issue_instr_buffer_if #(
    parameter int unsigned INSTR_W = 64,
    parameter int unsigned DEPTH   = 4
);
    logic                       flush_i;
    logic [INSTR_W-1:0]         instr_i;
    logic                       is_ctrl_flow_i;
    logic                       instr_valid_i;
    logic                       instr_ready_o;
    logic [INSTR_W-1:0]         decoded_instr_o;
    logic                       decoded_instr_valid_o;
    logic                       is_ctrl_flow_o;
    logic                       decoded_instr_ack_i;
    logic                       resolve_branch_i;
    logic [$clog2(DEPTH+1)-1:0] count_o;

    modport slave (
        input  flush_i, instr_i, is_ctrl_flow_i, instr_valid_i,
               decoded_instr_ack_i, resolve_branch_i,
        output instr_ready_o, decoded_instr_o, decoded_instr_valid_o,
               is_ctrl_flow_o, count_o
    );

    modport master (
        output flush_i, instr_i, is_ctrl_flow_i, instr_valid_i,
               decoded_instr_ack_i, resolve_branch_i,
        input  instr_ready_o, decoded_instr_o, decoded_instr_valid_o,
               is_ctrl_flow_o, count_o
    );
endinterface

// File: rtl/issue_instr_buffer.sv
// rtl/issue_instr_buffer.sv - decoupling FIFO between decode and issue with branch gate
//
// Ports:
//   clk_i  in   clock
//   rst_i  in   asynchronous reset, active-high
//   bus    slave modport of issue_instr_buffer_if (decode push side, issue pop side,
//          flush, branch resolve, occupancy)
// Parameters:
//   INSTR_W  width of one decoded instruction (scoreboard entry)
//   DEPTH    FIFO entries, power of two, >= 2
// Optional feature macro: ISSUE_BUF_BYPASS_EN
//   When defined, an instruction arriving at an empty, ungated buffer is presented to
//   issue in the same cycle; if it is acked that cycle it is never written.

module issue_instr_buffer #(
    parameter int unsigned INSTR_W = 64,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    issue_instr_buffer_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [INSTR_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]   mem_ctrl;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               branch_pend_q;

    logic empty;
    logic full;
    logic bypass;
    logic pop;
    logic pop_mem;
    logic push;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CNT_W'(DEPTH));

`ifdef ISSUE_BUF_BYPASS_EN
        bypass = empty & bus.instr_valid_i & ~bus.flush_i & ~branch_pend_q;
`else
        bypass = 1'b0;
`endif

        // Ready ignores a same-cycle pop so a full buffer never pushes through.
        bus.instr_ready_o         = ~full & ~bus.flush_i;
        bus.decoded_instr_valid_o = (~empty | bypass) & ~branch_pend_q & ~bus.flush_i;
        bus.decoded_instr_o       = bypass ? bus.instr_i        : mem_data[rd_ptr_q];
        bus.is_ctrl_flow_o        = bypass ? bus.is_ctrl_flow_i : mem_ctrl[rd_ptr_q];
        bus.count_o               = count_q;

        pop     = bus.decoded_instr_valid_o & bus.decoded_instr_ack_i;
        pop_mem = pop & ~bypass;
        // A bypassed instruction consumed in the same cycle never lands in storage.
        push    = bus.instr_valid_i & bus.instr_ready_o & ~(bypass & pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_data[i] <= '0;
            end
            mem_ctrl      <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            branch_pend_q <= 1'b0;
        end else if (bus.flush_i) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            branch_pend_q <= 1'b0;
        end else begin
            if (push) begin
                mem_data[wr_ptr_q] <= bus.instr_i;
                mem_ctrl[wr_ptr_q] <= bus.is_ctrl_flow_i;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_mem) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop_mem})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // Only one branch can be in flight, so a new one issued in the same
            // cycle as a resolve must keep the gate closed.
            if (pop & bus.is_ctrl_flow_o) begin
                branch_pend_q <= 1'b1;
            end else if (bus.resolve_branch_i) begin
                branch_pend_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_issue_instr_buffer.sv
// tb/tb_issue_instr_buffer.sv - directed and randomized checks for issue_instr_buffer

module tb_issue_instr_buffer;
    localparam int unsigned W = 32;
    localparam int unsigned D = 4;
`ifdef ISSUE_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    issue_instr_buffer_if #(.INSTR_W(W), .DEPTH(D)) bus ();

    issue_instr_buffer #(.INSTR_W(W), .DEPTH(D)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush_i             = 1'b0;
        bus.instr_i             = '0;
        bus.is_ctrl_flow_i      = 1'b0;
        bus.instr_valid_i       = 1'b0;
        bus.decoded_instr_ack_i = 1'b0;
        bus.resolve_branch_i    = 1'b0;
    endtask

    task automatic push1(input logic [W-1:0] d, input logic c);
        bus.instr_valid_i  = 1'b1;
        bus.instr_i        = d;
        bus.is_ctrl_flow_i = c;
        tick();
        bus.instr_valid_i  = 1'b0;
        bus.is_ctrl_flow_i = 1'b0;
    endtask

    logic [W:0] q[$];
    logic       m_pend;
    logic       e_ready;
    logic       e_valid;
    logic       m_byp;
    logic [W:0] e_head;
    logic [W:0] popped;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        check("rst_count", 64'(bus.count_o), 64'd0);
        check("rst_valid", 64'(bus.decoded_instr_valid_o), 64'd0);
        check("rst_ready", 64'(bus.instr_ready_o), 64'd1);
        check("rst_data",  64'(bus.decoded_instr_o), 64'd0);
        check("rst_ctrl",  64'(bus.is_ctrl_flow_o), 64'd0);
        rst = 1'b0;
        tick();

        // In-order delivery of A, B, C
        push1(32'hA000_000A, 1'b0);
        push1(32'hB000_000B, 1'b0);
        push1(32'hC000_000C, 1'b0);
        #1;
        check("abc_count", 64'(bus.count_o), 64'd3);
        check("abc_head",  64'(bus.decoded_instr_o), 64'hA000_000A);
        check("abc_valid", 64'(bus.decoded_instr_valid_o), 64'd1);
        bus.decoded_instr_ack_i = 1'b1;
        tick();
        check("abc_pop_b", 64'(bus.decoded_instr_o), 64'hB000_000B);
        tick();
        check("abc_pop_c", 64'(bus.decoded_instr_o), 64'hC000_000C);
        tick();
        bus.decoded_instr_ack_i = 1'b0;
        #1;
        check("abc_empty_count", 64'(bus.count_o), 64'd0);
        check("abc_empty_valid", 64'(bus.decoded_instr_valid_o), 64'd0);

        // Full buffer: push+ack in the same cycle pops only
        for (int i = 0; i < int'(D); i++) push1(32'hD000_0000 + 32'(i), 1'b0);
        #1;
        check("full_count", 64'(bus.count_o), 64'd4);
        check("full_ready", 64'(bus.instr_ready_o), 64'd0);
        bus.instr_valid_i       = 1'b1;
        bus.instr_i             = 32'hE000_000E;
        bus.decoded_instr_ack_i = 1'b1;
        tick();
        idle();
        #1;
        check("full_pushpop_count", 64'(bus.count_o), 64'd3);
        check("full_pushpop_head",  64'(bus.decoded_instr_o), 64'hD000_0001);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        #1;
        check("flush_clears", 64'(bus.count_o), 64'd0);

        // Branch gate
        push1(32'h0000_0B00, 1'b1);
        push1(32'h0000_0F0F, 1'b0);
        #1;
        check("br_head_ctrl", 64'(bus.is_ctrl_flow_o), 64'd1);
        bus.decoded_instr_ack_i = 1'b1;
        tick();
        bus.decoded_instr_ack_i = 1'b1;
        #1;
        check("br_gated_valid", 64'(bus.decoded_instr_valid_o), 64'd0);
        tick();
        bus.decoded_instr_ack_i = 1'b0;
        #1;
        check("br_ack_ignored_count", 64'(bus.count_o), 64'd1);
        bus.resolve_branch_i = 1'b1;
        tick();
        bus.resolve_branch_i = 1'b0;
        #1;
        check("br_resolved_valid", 64'(bus.decoded_instr_valid_o), 64'd1);
        check("br_resolved_head",  64'(bus.decoded_instr_o), 64'h0000_0F0F);
        bus.decoded_instr_ack_i = 1'b1;
        tick();
        bus.decoded_instr_ack_i = 1'b0;

        // Set and resolve in the same cycle: gate stays closed
        push1(32'h0000_0B02, 1'b1);
        bus.decoded_instr_ack_i = 1'b1;
        bus.resolve_branch_i    = 1'b1;
        tick();
        idle();
        push1(32'h0000_1111, 1'b0);
        #1;
        check("br_setwins_valid", 64'(bus.decoded_instr_valid_o), 64'd0);
        check("br_setwins_count", 64'(bus.count_o), 64'd1);
        bus.resolve_branch_i = 1'b1;
        tick();
        bus.resolve_branch_i = 1'b0;
        #1;
        check("br_setwins_release", 64'(bus.decoded_instr_o), 64'h0000_1111);
        bus.decoded_instr_ack_i = 1'b1;
        tick();
        bus.decoded_instr_ack_i = 1'b0;

        // Flush with pending branch and a push attempt
        push1(32'h0000_0B03, 1'b1);
        push1(32'h0000_2222, 1'b0);
        push1(32'h0000_3333, 1'b0);
        bus.decoded_instr_ack_i = 1'b1;
        tick();
        bus.decoded_instr_ack_i = 1'b0;
        push1(32'h0000_4444, 1'b0);
        #1;
        check("fl_pre_count", 64'(bus.count_o), 64'd3);
        bus.flush_i       = 1'b1;
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = 32'h0000_5555;
        #1;
        check("fl_ready", 64'(bus.instr_ready_o), 64'd0);
        check("fl_valid", 64'(bus.decoded_instr_valid_o), 64'd0);
        tick();
        idle();
        #1;
        check("fl_post_count", 64'(bus.count_o), 64'd0);
        push1(32'h0000_6666, 1'b0);
        #1;
        check("fl_pend_cleared", 64'(bus.decoded_instr_valid_o), 64'd1);
        check("fl_no_stale_push", 64'(bus.decoded_instr_o), 64'h0000_6666);
        bus.decoded_instr_ack_i = 1'b1;
        tick();
        idle();

        // Bypass / minimum latency on an empty buffer
        bus.instr_valid_i       = 1'b1;
        bus.instr_i             = 32'h0000_DDDD;
        bus.decoded_instr_ack_i = 1'b1;
        #1;
        if (BYP) begin
            check("byp_valid", 64'(bus.decoded_instr_valid_o), 64'd1);
            check("byp_data",  64'(bus.decoded_instr_o), 64'h0000_DDDD);
            tick();
            idle();
            #1;
            check("byp_count", 64'(bus.count_o), 64'd0);
        end else begin
            check("nobyp_valid0", 64'(bus.decoded_instr_valid_o), 64'd0);
            tick();
            bus.instr_valid_i = 1'b0;
            #1;
            check("nobyp_valid1", 64'(bus.decoded_instr_valid_o), 64'd1);
            check("nobyp_data",   64'(bus.decoded_instr_o), 64'h0000_DDDD);
            tick();
            idle();
            #1;
            check("nobyp_count", 64'(bus.count_o), 64'd0);
        end

        // Asynchronous reset mid-operation
        push1(32'h0000_7777, 1'b1);
        push1(32'h0000_8888, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_count", 64'(bus.count_o), 64'd0);
        check("arst_data",  64'(bus.decoded_instr_o), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic against a queue model
        q.delete();
        m_pend = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.flush_i             = ($urandom_range(31) == 0);
            bus.instr_valid_i       = ($urandom_range(2) != 0);
            bus.instr_i             = $urandom;
            bus.is_ctrl_flow_i      = ($urandom_range(3) == 0);
            bus.decoded_instr_ack_i = $urandom_range(1);
            bus.resolve_branch_i    = ($urandom_range(3) == 0);
            #1;
            m_byp   = BYP && (q.size() == 0) && bus.instr_valid_i && !bus.flush_i && !m_pend;
            e_ready = (q.size() < D) && !bus.flush_i;
            e_valid = ((q.size() > 0) || m_byp) && !m_pend && !bus.flush_i;
            e_head  = m_byp ? {bus.is_ctrl_flow_i, bus.instr_i} : ((q.size() > 0) ? q[0] : '0);
            check("rnd_ready", 64'(bus.instr_ready_o), 64'(e_ready));
            check("rnd_valid", 64'(bus.decoded_instr_valid_o), 64'(e_valid));
            if (e_valid) begin
                check("rnd_head", 64'({bus.is_ctrl_flow_o, bus.decoded_instr_o}), 64'(e_head));
            end
            if (bus.flush_i) begin
                q.delete();
                m_pend = 1'b0;
            end else begin
                popped = '0;
                if (e_valid && bus.decoded_instr_ack_i) begin
                    popped = e_head;
                    if (!m_byp) void'(q.pop_front());
                end
                if (bus.instr_valid_i && e_ready &&
                    !(m_byp && e_valid && bus.decoded_instr_ack_i)) begin
                    q.push_back({bus.is_ctrl_flow_i, bus.instr_i});
                end
                if (e_valid && bus.decoded_instr_ack_i && popped[W]) m_pend = 1'b1;
                else if (bus.resolve_branch_i) m_pend = 1'b0;
            end
            tick();
            check("rnd_count", 64'(bus.count_o), 64'(q.size()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
